// File: rtl/tape_player_if.sv
// Loader/player/status signal bundle for the tape player. The loader side
// (master) drives timing, control and bytes; the player side (slave) returns status.
interface tape_player_if;
   logic        ce;
   logic        play;
   logic        pause;
   logic [7:0]  din;
   logic        din_valid;
   logic        din_last;
   logic        din_ready;
   logic        tapein;
   logic        busy;
   logic        underrun;
   logic [15:0] byte_cnt;

   modport master (
      output ce, play, pause, din, din_valid, din_last,
      input  din_ready, tapein, busy, underrun, byte_cnt
   );

   modport slave (
      input  ce, play, pause, din, din_valid, din_last,
      output din_ready, tapein, busy, underrun, byte_cnt
   );
endinterface

// File: rtl/tape_player.sv
// Tape-image player: buffers loader bytes in a small FIFO and serialises them
// MSB-first as Manchester half-bit pairs onto the PPI tape-in line.
module tape_player #(
   parameter int HALF_BIT   = 250,
   parameter int FIFO_DEPTH = 4
) (
   input  logic          clk_sys,
   input  logic          reset,
   tape_player_if.slave  bus
);
   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_HALF1, S_HALF2, S_STALL, S_DONE
   } state_t;

   localparam int             PTR_W     = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0] DEPTH_C   = FIFO_DEPTH[PTR_W:0];
   localparam logic [9:0]     HALF_LAST = HALF_BIT[9:0] - 10'd1;

   state_t           state_q;
   logic [8:0]       mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W:0]   count_q;
   logic [7:0]       shifter_q;
   logic             last_q;
   logic [2:0]       bit_idx_q;
   logic [9:0]       half_cnt_q;
   logic             tapein_q;
   logic             busy_q;
   logic             underrun_q;
   logic [15:0]      byte_cnt_q;
   logic             play_prev_q;

   logic             empty_s;
   logic             full_s;
   logic             push_s;
   logic             pop_s;
   logic             abort_s;
   logic             tick_s;
   logic             half_end_s;
   logic [8:0]       head_s;

   assign empty_s    = (count_q == '0);
   assign full_s     = (count_q == DEPTH_C);
   assign push_s     = bus.din_valid & ~full_s;
   assign pop_s      = (state_q == S_LOAD) & bus.play;
   // Flush only when play falls, so the loader can pre-fill the FIFO while stopped.
   assign abort_s    = play_prev_q & ~bus.play;
   assign tick_s     = bus.ce & ~bus.pause;
   assign half_end_s = tick_s & (half_cnt_q == HALF_LAST);
   assign head_s     = mem_q[rd_ptr_q];

   assign bus.din_ready = ~full_s;
   assign bus.tapein    = tapein_q;
   assign bus.busy      = busy_q;
   assign bus.underrun  = underrun_q;
   assign bus.byte_cnt  = byte_cnt_q;

   // Input FIFO storage, pointers and occupancy; an abort flush wins over a push.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 9'd0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         play_prev_q <= 1'b0;
      end else begin
         play_prev_q <= bus.play;
         if (abort_s) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
         end else begin
            if (push_s) begin
               mem_q[wr_ptr_q] <= {bus.din_last, bus.din};
               wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_s) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_s, pop_s})
               2'b10:   count_q <= count_q + 1'b1;
               2'b01:   count_q <= count_q - 1'b1;
               default: count_q <= count_q;
            endcase
         end
      end
   end

   // Serialiser FSM with registered tapein/busy/underrun/byte_cnt.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         shifter_q  <= 8'd0;
         last_q     <= 1'b0;
         bit_idx_q  <= 3'd0;
         half_cnt_q <= 10'd0;
         tapein_q   <= 1'b0;
         busy_q     <= 1'b0;
         underrun_q <= 1'b0;
         byte_cnt_q <= 16'd0;
      end else if (!bus.play) begin
         state_q    <= S_IDLE;
         half_cnt_q <= 10'd0;
         tapein_q   <= 1'b0;
         busy_q     <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               tapein_q <= 1'b0;
               if (!empty_s) begin
                  state_q    <= S_LOAD;
                  busy_q     <= 1'b1;
                  byte_cnt_q <= 16'd0;
               end
            end
            S_LOAD: begin
               shifter_q  <= head_s[7:0];
               last_q     <= head_s[8];
               bit_idx_q  <= 3'd7;
               half_cnt_q <= 10'd0;
               byte_cnt_q <= byte_cnt_q + 16'd1;
               tapein_q   <= ~head_s[7];
               state_q    <= S_HALF1;
            end
            S_HALF1: begin
               if (half_end_s) begin
                  half_cnt_q <= 10'd0;
                  tapein_q   <= shifter_q[bit_idx_q];
                  state_q    <= S_HALF2;
               end else if (tick_s) begin
                  half_cnt_q <= half_cnt_q + 10'd1;
               end
            end
            S_HALF2: begin
               if (half_end_s) begin
                  half_cnt_q <= 10'd0;
                  if (bit_idx_q != 3'd0) begin
                     bit_idx_q <= bit_idx_q - 3'd1;
                     tapein_q  <= ~shifter_q[bit_idx_q - 3'd1];
                     state_q   <= S_HALF1;
                  end else if (last_q) begin
                     tapein_q <= 1'b0;
                     busy_q   <= 1'b0;
                     state_q  <= S_DONE;
                  end else if (!empty_s) begin
                     state_q <= S_LOAD;
                  end else begin
                     underrun_q <= 1'b1;
                     state_q    <= S_STALL;
                  end
               end else if (tick_s) begin
                  half_cnt_q <= half_cnt_q + 10'd1;
               end
            end
            S_STALL: begin
               if (!empty_s) state_q <= S_LOAD;
            end
            S_DONE: begin
               tapein_q <= 1'b0;
               busy_q   <= 1'b0;
            end
            default: begin
               state_q  <= S_IDLE;
               tapein_q <= 1'b0;
               busy_q   <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_tape_player.sv
// Self-checking bench for tape_player: two instances (HALF_BIT 4 and 8) driven
// cycle by cycle, with a queue of expected half-bit levels for serial checks.
module tb_tape_player;
   logic clk_sys = 1'b0;
   logic reset   = 1'b1;
   int   n_checks = 0;
   int   n_pass   = 0;
   logic exp_q [$];

   tape_player_if bus4();
   tape_player_if bus8();

   tape_player #(.HALF_BIT(4), .FIFO_DEPTH(4)) dut4 (.clk_sys(clk_sys), .reset(reset), .bus(bus4));
   tape_player #(.HALF_BIT(8), .FIFO_DEPTH(4)) dut8 (.clk_sys(clk_sys), .reset(reset), .bus(bus8));

   always #5 clk_sys = ~clk_sys;

   // one clk_sys cycle with optional ce; returns 1 time unit after the edge
   task automatic clk1(input logic ce_v);
      bus4.ce = ce_v;
      bus8.ce = ce_v;
      @(posedge clk_sys);
      #1;
      bus4.ce = 1'b0;
      bus8.ce = 1'b0;
   endtask

   task automatic push(input bit sel8, input logic [7:0] b, input logic last);
      if (sel8) begin
         bus8.din = b; bus8.din_last = last; bus8.din_valid = 1'b1;
      end else begin
         bus4.din = b; bus4.din_last = last; bus4.din_valid = 1'b1;
      end
      clk1(1'b0);
      bus4.din_valid = 1'b0;
      bus8.din_valid = 1'b0;
   endtask

   task automatic do_reset();
      bus4.play = 1'b0; bus4.pause = 1'b0; bus4.din_valid = 1'b0;
      bus8.play = 1'b0; bus8.pause = 1'b0; bus8.din_valid = 1'b0;
      reset = 1'b1;
      #2;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      n_checks++; if (bus4.tapein !== 1'b0) $display("FAIL rst_tapein: got %b want 0", bus4.tapein); else n_pass++;
      n_checks++; if (bus4.busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus4.busy); else n_pass++;
      n_checks++; if (bus4.underrun !== 1'b0) $display("FAIL rst_underrun: got %b want 0", bus4.underrun); else n_pass++;
      n_checks++; if (bus4.byte_cnt !== 16'd0) $display("FAIL rst_byte_cnt: got %h want 0000", bus4.byte_cnt); else n_pass++;
      n_checks++; if (bus4.din_ready !== 1'b1) $display("FAIL rst_din_ready: got %b want 1", bus4.din_ready); else n_pass++;
      clk1(1'b0);
      do_reset();
   endtask

   // push up to two bytes (last flag on the final one) and check every half level
   task automatic test_stream(input string name, input int nbytes, input logic [7:0] b0, input logic [7:0] b1);
      logic [7:0] bytes [2];
      logic       e;
      do_reset();
      bytes[0] = b0;
      bytes[1] = b1;
      for (int k = 0; k < nbytes; k++) begin
         push(1'b0, bytes[k], (k == nbytes - 1));
         for (int i = 7; i >= 0; i--) begin
            exp_q.push_back(~bytes[k][i]);
            exp_q.push_back(bytes[k][i]);
         end
      end
      bus4.play = 1'b1;
      clk1(1'b0);
      clk1(1'b0);
      for (int h = 0; h < 16 * nbytes; h++) begin
         if (h > 0 && (h % 16) == 0) clk1(1'b1);
         e = exp_q.pop_front();
         n_checks++;
         if (bus4.tapein !== e) $display("FAIL %s_half%0d: got %b want %b", name, h, bus4.tapein, e); else n_pass++;
         for (int t = 0; t < 4; t++) clk1(1'b1);
      end
      n_checks++; if (bus4.tapein !== 1'b0) $display("FAIL %s_done_tapein: got %b want 0", name, bus4.tapein); else n_pass++;
      n_checks++; if (bus4.busy !== 1'b0) $display("FAIL %s_done_busy: got %b want 0", name, bus4.busy); else n_pass++;
      n_checks++; if (bus4.byte_cnt !== 16'(nbytes)) $display("FAIL %s_byte_cnt: got %0d want %0d", name, bus4.byte_cnt, nbytes); else n_pass++;
      bus4.play = 1'b0;
      clk1(1'b0);
   endtask

   task automatic test_fifo_fill();
      do_reset();
      for (int k = 0; k < 4; k++) begin
         push(1'b0, 8'(8'h10 + k), 1'b0);
         n_checks++;
         if (bus4.din_ready !== (k < 3)) $display("FAIL fill_ready%0d: got %b want %b", k, bus4.din_ready, (k < 3)); else n_pass++;
      end
      bus4.din = 8'h55; bus4.din_last = 1'b0; bus4.din_valid = 1'b1;
      bus4.play = 1'b1;
      clk1(1'b0);
      n_checks++; if (bus4.din_ready !== 1'b0) $display("FAIL fill_ready_load: got %b want 0", bus4.din_ready); else n_pass++;
      clk1(1'b0);
      n_checks++; if (bus4.din_ready !== 1'b1) $display("FAIL fill_ready_pop: got %b want 1", bus4.din_ready); else n_pass++;
      n_checks++; if (bus4.byte_cnt !== 16'd1) $display("FAIL fill_cnt1: got %0d want 1", bus4.byte_cnt); else n_pass++;
      clk1(1'b0);
      bus4.din_valid = 1'b0;
      n_checks++; if (bus4.din_ready !== 1'b0) $display("FAIL fill_ready_5th: got %b want 0", bus4.din_ready); else n_pass++;
      for (int c = 0; c < 400; c++) clk1(1'b1);
      n_checks++; if (bus4.byte_cnt !== 16'd5) $display("FAIL fill_cnt5: got %0d want 5", bus4.byte_cnt); else n_pass++;
      n_checks++; if (bus4.underrun !== 1'b1) $display("FAIL fill_underrun: got %b want 1", bus4.underrun); else n_pass++;
      n_checks++; if (bus4.busy !== 1'b1) $display("FAIL fill_busy: got %b want 1", bus4.busy); else n_pass++;
   endtask

   task automatic test_underrun();
      do_reset();
      push(1'b0, 8'h00, 1'b0);
      bus4.play = 1'b1;
      clk1(1'b0);
      clk1(1'b0);
      for (int c = 0; c < 64; c++) clk1(1'b1);
      n_checks++; if (bus4.underrun !== 1'b1) $display("FAIL ur_set: got %b want 1", bus4.underrun); else n_pass++;
      n_checks++; if (bus4.tapein !== 1'b0) $display("FAIL ur_tapein: got %b want 0", bus4.tapein); else n_pass++;
      n_checks++; if (bus4.busy !== 1'b1) $display("FAIL ur_busy: got %b want 1", bus4.busy); else n_pass++;
      push(1'b0, 8'hFF, 1'b0);
      clk1(1'b0);
      clk1(1'b0);
      n_checks++; if (bus4.byte_cnt !== 16'd2) $display("FAIL ur_cnt: got %0d want 2", bus4.byte_cnt); else n_pass++;
      n_checks++; if (bus4.underrun !== 1'b1) $display("FAIL ur_sticky: got %b want 1", bus4.underrun); else n_pass++;
      for (int c = 0; c < 4; c++) clk1(1'b1);
      n_checks++; if (bus4.tapein !== 1'b1) $display("FAIL ur_ff_half2: got %b want 1", bus4.tapein); else n_pass++;
   endtask

   task automatic test_pause();
      logic moved;
      do_reset();
      push(1'b1, 8'h80, 1'b1);
      bus8.play = 1'b1;
      clk1(1'b0);
      clk1(1'b0);
      for (int c = 0; c < 3; c++) clk1(1'b1);
      n_checks++; if (bus8.tapein !== 1'b0) $display("FAIL pause_pre: got %b want 0", bus8.tapein); else n_pass++;
      bus8.pause = 1'b1;
      moved = 1'b0;
      for (int c = 0; c < 100; c++) begin
         clk1(1'b1);
         if (bus8.tapein !== 1'b0) moved = 1'b1;
      end
      n_checks++; if (moved !== 1'b0) $display("FAIL pause_hold: got %b want 0", moved); else n_pass++;
      bus8.pause = 1'b0;
      for (int c = 0; c < 4; c++) clk1(1'b1);
      n_checks++; if (bus8.tapein !== 1'b0) $display("FAIL pause_tick7: got %b want 0", bus8.tapein); else n_pass++;
      clk1(1'b1);
      n_checks++; if (bus8.tapein !== 1'b1) $display("FAIL pause_tick8: got %b want 1", bus8.tapein); else n_pass++;
   endtask

   task automatic test_abort();
      do_reset();
      push(1'b0, 8'h00, 1'b0);
      bus4.play = 1'b1;
      clk1(1'b0);
      clk1(1'b0);
      for (int c = 0; c < 64; c++) clk1(1'b1);
      push(1'b0, 8'hFF, 1'b0);
      push(1'b0, 8'h12, 1'b0);
      clk1(1'b0);
      for (int c = 0; c < 10; c++) clk1(1'b1);
      push(1'b0, 8'h34, 1'b0);
      n_checks++; if (bus4.underrun !== 1'b1) $display("FAIL abort_pre_ur: got %b want 1", bus4.underrun); else n_pass++;
      bus4.play = 1'b0;
      clk1(1'b0);
      n_checks++; if (bus4.tapein !== 1'b0) $display("FAIL abort_tapein: got %b want 0", bus4.tapein); else n_pass++;
      n_checks++; if (bus4.busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", bus4.busy); else n_pass++;
      n_checks++; if (bus4.underrun !== 1'b0) $display("FAIL abort_ur: got %b want 0", bus4.underrun); else n_pass++;
      n_checks++; if (bus4.din_ready !== 1'b1) $display("FAIL abort_ready: got %b want 1", bus4.din_ready); else n_pass++;
      n_checks++; if (bus4.byte_cnt !== 16'd2) $display("FAIL abort_cnt: got %0d want 2", bus4.byte_cnt); else n_pass++;
      bus4.play = 1'b1;
      for (int c = 0; c < 3; c++) clk1(1'b0);
      n_checks++; if (bus4.busy !== 1'b0) $display("FAIL abort_flushed: got %b want 0", bus4.busy); else n_pass++;
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int k = 0; k < 4; k++) push(1'b0, 8'hFF, 1'b0);
      bus4.play = 1'b1;
      clk1(1'b0);
      clk1(1'b0);
      push(1'b0, 8'hFF, 1'b0);
      for (int c = 0; c < 6; c++) clk1(1'b1);
      n_checks++; if (bus4.tapein !== 1'b1) $display("FAIL ar_pre_tapein: got %b want 1", bus4.tapein); else n_pass++;
      n_checks++; if (bus4.din_ready !== 1'b0) $display("FAIL ar_pre_ready: got %b want 0", bus4.din_ready); else n_pass++;
      #2;
      reset = 1'b1;
      #1;
      n_checks++; if (bus4.tapein !== 1'b0) $display("FAIL ar_tapein: got %b want 0", bus4.tapein); else n_pass++;
      n_checks++; if (bus4.busy !== 1'b0) $display("FAIL ar_busy: got %b want 0", bus4.busy); else n_pass++;
      n_checks++; if (bus4.byte_cnt !== 16'd0) $display("FAIL ar_cnt: got %0d want 0", bus4.byte_cnt); else n_pass++;
      n_checks++; if (bus4.din_ready !== 1'b1) $display("FAIL ar_ready: got %b want 1", bus4.din_ready); else n_pass++;
      #1;
      reset = 1'b0;
      for (int c = 0; c < 3; c++) clk1(1'b1);
      n_checks++; if (bus4.busy !== 1'b0) $display("FAIL ar_fifo_empty: got %b want 0", bus4.busy); else n_pass++;
      bus4.play = 1'b0;
      clk1(1'b0);
   endtask

   initial begin
      bus4.ce = 1'b0; bus4.play = 1'b0; bus4.pause = 1'b0;
      bus4.din = 8'h00; bus4.din_valid = 1'b0; bus4.din_last = 1'b0;
      bus8.ce = 1'b0; bus8.play = 1'b0; bus8.pause = 1'b0;
      bus8.din = 8'h00; bus8.din_valid = 1'b0; bus8.din_last = 1'b0;
      test_reset();
      test_stream("a5", 1, 8'hA5, 8'h00);
      test_stream("b2b", 2, 8'h3C, 8'hC3);
      test_fifo_fill();
      test_underrun();
      test_pause();
      test_abort();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
